// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan encoder.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned CODE_W   = 4;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Index of the lowest-numbered closed (low) row.
    function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines; idles high (no key).
module keypad_row_sync
    import keypad_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_ROWS-1:0] rs
);

    logic [NUM_ROWS-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '1;
            rs   <= '1;
        end else begin
            meta <= row;
            rs   <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner with debounce and 4-bit encoding feeding a FIFO write port.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned REPEAT_DELAY    = 50000,
    parameter int unsigned REPEAT_RATE     = 10000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    input  logic                full,
    output logic [CODE_W-1:0]   code,
    output logic                wr_enable,
    output logic                dropped,
    output logic                key_down
);

    localparam int unsigned MAX_P =
        max2(max2(SCAN_DIV, DEBOUNCE_CYCLES), max2(REPEAT_DELAY, REPEAT_RATE));
    localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

    state_t              state;
    logic [1:0]          c_idx;
    logic [1:0]          r_idx;
    logic [NUM_ROWS-1:0] pat;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_ROWS-1:0] rs;

`ifdef KEYPAD_REPEAT_EN
    logic [CNT_W-1:0]    rpt_cnt;
    logic                rpt_on;
    logic                rpt_first;
`endif

    keypad_row_sync u_sync (
        .clock (clock),
        .reset (reset),
        .row   (row),
        .rs    (rs)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SCAN;
            c_idx     <= 2'd0;
            r_idx     <= 2'd0;
            pat       <= '1;
            cnt       <= '0;
            col       <= 4'b1110;
            code      <= '0;
            wr_enable <= 1'b0;
            dropped   <= 1'b0;
            key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_on    <= 1'b0;
            rpt_first <= 1'b1;
`endif
        end else begin
            wr_enable <= 1'b0;
            dropped   <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (cnt == CNT_W'(SCAN_DIV - 1)) begin
                        cnt <= '0;
                        if (rs == '1) begin
                            c_idx <= c_idx + 2'd1;
                            col   <= col_drive(c_idx + 2'd1);
                        end else begin
                            r_idx <= lowest_low(rs);
                            pat   <= rs;
                            state <= DEBOUNCE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (rs == pat) begin
                        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                            cnt   <= '0;
                            state <= EMIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt   <= '0;
                        c_idx <= c_idx + 2'd1;
                        col   <= col_drive(c_idx + 2'd1);
                        state <= SCAN;
                    end
                end
                EMIT: begin
                    code     <= {r_idx, c_idx};
                    key_down <= 1'b1;
                    if (!full) wr_enable <= 1'b1;
                    else       dropped   <= 1'b1;
                    cnt      <= '0;
                    state    <= WAIT_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                    rpt_cnt   <= '0;
                    rpt_on    <= 1'b1;
                    rpt_first <= 1'b1;
`endif
                end
                WAIT_RELEASE: begin
                    if (rs == '1) begin
                        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                            cnt      <= '0;
                            key_down <= 1'b0;
                            c_idx    <= c_idx + 2'd1;
                            col      <= col_drive(c_idx + 2'd1);
                            state    <= SCAN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    // Any deviation from the latched pattern ends repeat for this press.
                    if (rs != pat) begin
                        rpt_on <= 1'b0;
                    end else if (rpt_on) begin
                        if (rpt_cnt == (rpt_first ? CNT_W'(REPEAT_DELAY - 1)
                                                  : CNT_W'(REPEAT_RATE - 1))) begin
                            rpt_cnt   <= '0;
                            rpt_first <= 1'b0;
                            if (!full) wr_enable <= 1'b1;
                            else       dropped   <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Self-checking bench for keypad_scan_encoder: directed scenarios plus randomized presses.
module tb_keypad_scan_encoder;

    localparam int unsigned SD = 4;
    localparam int unsigned DC = 8;
    localparam int unsigned RD = 40;
    localparam int unsigned RR = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic       full = 1'b0;
    logic [3:0] code;
    logic       wr_enable;
    logic       dropped;
    logic       key_down;

    // Keypad matrix model: a closed key pulls its row low while its column is driven.
    logic       key_on = 1'b0;
    logic [1:0] key_r  = 2'd0;
    logic [1:0] key_c  = 2'd0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_wr        = 0;
    int n_drop      = 0;
    int pulse_q[$];

    always #5 clock = ~clock;

    always_comb begin
        row = 4'hF;
        if (key_on && !col[key_c]) row[key_r] = 1'b0;
    end

    keypad_scan_encoder #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .full      (full),
        .code      (code),
        .wr_enable (wr_enable),
        .dropped   (dropped),
        .key_down  (key_down)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (wr_enable) begin
            n_wr++;
            pulse_q.push_back(cyc);
        end
        if (dropped) n_drop++;
        if (wr_enable && dropped) check("wr_and_dropped", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_counts();
        n_wr   = 0;
        n_drop = 0;
        pulse_q.delete();
    endtask

    // Wait (bounded) for the first strobe or drop of a press.
    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        while (n_wr + n_drop == 0 && n < 120) begin
            tick();
            n++;
        end
        check({tag, "_detect"}, n_wr + n_drop, 1);
    endtask

    task automatic release_and_check(input string tag);
        key_on = 1'b0;
        for (int i = 0; i < int'(DC); i++) tick();
        check({tag, "_kd_held"}, key_down, 1);
        for (int i = 0; i < 4; i++) tick();
        check({tag, "_kd_released"}, key_down, 0);
    endtask

    task automatic press_and_check(input string tag, input logic [1:0] r, input logic [1:0] c,
                                   input logic f);
        clear_counts();
        full   = f;
        key_r  = r;
        key_c  = c;
        key_on = 1'b1;
        wait_strobe(tag);
        check({tag, "_wr"}, n_wr, f ? 0 : 1);
        check({tag, "_drop"}, n_drop, f ? 1 : 0);
        check({tag, "_code"}, code, {r, c});
        check({tag, "_kd"}, key_down, 1);
        tick();
        check({tag, "_one_cycle"}, {wr_enable, dropped}, 0);
        for (int i = 0; i < 20; i++) tick();
        release_and_check(tag);
        check({tag, "_total"}, n_wr + n_drop, 1);
        full = 1'b0;
    endtask

    initial begin
        // 1: reset state and idle column rotation
        do_reset();
        check("rst_col", col, 4'b1110);
        check("rst_code", code, 0);
        check("rst_wr", wr_enable, 0);
        check("rst_drop", dropped, 0);
        check("rst_kd", key_down, 0);
        clear_counts();
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("idle_col", col, ~(32'd1 << ((k / SD) % 4)) & 32'hF);
        end
        check("idle_no_wr", n_wr + n_drop, 0);

        // 2: row 2 / col 1
        press_and_check("key_2_1", 2'd2, 2'd1, 1'b0);

        // 3: bouncing contact in column 0 is rejected, then a stable press accepted
        do_reset();
        clear_counts();
        key_r = 2'd0;
        key_c = 2'd0;
        for (int i = 0; i < 30; i++) begin
            key_on = ((i / 3) % 2) == 0;
            tick();
        end
        check("bounce_no_wr", n_wr + n_drop, 0);
        press_and_check("bounce_settle", 2'd0, 2'd0, 1'b0);

        // 4: full drops the code, then a normal write after full clears
        press_and_check("full_drop", 2'd3, 2'd3, 1'b1);
        press_and_check("full_clear", 2'd3, 2'd3, 1'b0);

        // 5: reset during debounce
        do_reset();
        clear_counts();
        key_r  = 2'd1;
        key_c  = 2'd0;
        key_on = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("mid_hold_col", col, 4'b1110);
        reset = 1'b1;
        tick();
        check("mid_rst_col", col, 4'b1110);
        check("mid_rst_kd", key_down, 0);
        check("mid_rst_out", {wr_enable, dropped}, 0);
        key_on = 1'b0;
        reset  = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("mid_rst_no_wr", n_wr + n_drop, 0);

        // Randomized presses: each accepted press yields exactly one write or drop.
        for (int n = 0; n < 8; n++) begin
            logic [1:0] rr;
            logic [1:0] cc;
            logic       ff;
            rr = 2'($urandom_range(0, 3));
            cc = 2'($urandom_range(0, 3));
            ff = 1'($urandom_range(0, 1));
            press_and_check("rand", rr, cc, ff);
            for (int i = 0; i < int'($urandom_range(0, 10)); i++) tick();
        end

`ifdef KEYPAD_REPEAT_EN
        // 6: auto-repeat while held
        begin
            int t0;
            int offs [5];
            offs = '{0, 40, 56, 72, 88};
            clear_counts();
            key_r  = 2'd1;
            key_c  = 2'd2;
            key_on = 1'b1;
            wait_strobe("rpt");
            t0 = cyc;
            for (int i = 0; i < 95; i++) tick();
            check("rpt_count", pulse_q.size(), 5);
            check("rpt_code", code, 4'b0110);
            for (int i = 0; i < 5; i++) begin
                if (i < pulse_q.size()) check("rpt_offset", pulse_q[i] - t0, offs[i]);
            end
            release_and_check("rpt");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
